// File: rtl/counter_datapath.sv
// counter_datapath: index/accumulator/output registers with a shared adder for the sum-of-integers CPU.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   sumSrcMuxSel   sum load source: 0 = zero, 1 = adder result
//   iSrcMuxSel     i load source: 0 = zero, 1 = adder result
//   sumLoad        load enable for sum
//   iLoad          load enable for i
//   outLoad        load enable for out (out <= sum)
//   adderSrcMuxSel adder operands: 0 = sum + i, 1 = i + 1
//   iLe10          combinational status i <= LIMIT
//   out            registered result
//   outValid       one-cycle pulse the cycle after an outLoad
//   ovf            sticky carry-out flag
module counter_datapath #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sumSrcMuxSel,
    input  logic             iSrcMuxSel,
    input  logic             sumLoad,
    input  logic             iLoad,
    input  logic             outLoad,
    input  logic             adderSrcMuxSel,
    output logic             iLe10,
    output logic [WIDTH-1:0] out,
    output logic             outValid,
    output logic             ovf
);
    localparam logic [31:0] LIM = LIMIT;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   adderFull;
    logic [WIDTH-1:0] adderResult;
    logic             carry;
    logic             setOvf;
    logic             clrOvf;
    always_comb begin
        adderFull   = {1'b0, i} + (adderSrcMuxSel ? (WIDTH+1)'(1) : {1'b0, sum});
        adderResult = adderFull[WIDTH-1:0];
        carry       = adderFull[WIDTH];
        // Only loads that actually take the adder result can raise the flag.
        setOvf      = carry && ((sumLoad && sumSrcMuxSel) || (iLoad && iSrcMuxSel));
        // Loop initialise (sum cleared) clears the flag and wins over a set.
        clrOvf      = sumLoad && !sumSrcMuxSel;
        iLe10       = (32'(i) <= LIM);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            i        <= '0;
            sum      <= '0;
            out      <= '0;
            outValid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (sumLoad) sum <= sumSrcMuxSel ? adderResult : '0;
            if (iLoad) i <= iSrcMuxSel ? adderResult : '0;
            if (outLoad) out <= sum;
            outValid <= outLoad;
            ovf      <= clrOvf ? 1'b0 : (setOvf ? 1'b1 : ovf);
        end
    end
endmodule

// File: doc/counter_datapath.md
Name: counter_datapath

Overview:
- Datapath for the sum-of-integers counter CPU; it is the other end of the control unit's control/status interface.
- Accepts the six per-cycle control strobes (mux selects and register loads) and returns the loop-condition status `iLe10`.
- Holds the loop index register `i`, the accumulator `sum` and the output register `out`, sharing a single adder.
- Adds a registered output-valid pulse and a sticky overflow flag for the display/top level.

Parameters:
- WIDTH, 8, width of the `i`, `sum` and `out` registers and of the shared adder.
- LIMIT, 10, loop bound; `iLe10` is asserted while `i` <= LIMIT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- sumSrcMuxSel  input  1  sum load source: 0 = constant 0, 1 = adder result.
- iSrcMuxSel  input  1  i load source: 0 = constant 0, 1 = adder result.
- sumLoad  input  1  load enable for `sum`.
- iLoad  input  1  load enable for `i`.
- outLoad  input  1  load enable for `out` (out <= sum).
- adderSrcMuxSel  input  1  adder operands: 0 = sum + i, 1 = i + 1.
- iLe10  output  1  combinational status, (i <= LIMIT), unsigned compare on the registered `i`.
- out  output  WIDTH  registered result.
- outValid  output  1  one-cycle pulse, high the cycle after an outLoad.
- ovf  output  1  sticky carry-out flag.

Behaviour:
- Reset (synchronous, active-high):
  - i, sum, out, outValid and ovf all go to 0 on the clocking edge.
  - iLe10 is therefore 1 after reset whenever LIMIT >= 0.
  - Reset overrides every control input in the same cycle.
  - Reset asserted mid-loop discards all partial state.
- Adder:
  - Adder is WIDTH+1 bits wide: a = i; b = sum when adderSrcMuxSel = 0, constant 1 when adderSrcMuxSel = 1.
  - adder_result is bits [WIDTH-1:0], wrapping modulo 2^WIDTH; carry is bit WIDTH.
- Register updates, per rising edge when not in reset:
  - sumLoad = 1: sum <= (sumSrcMuxSel ? adder_result : 0). sumLoad = 0: sum holds.
  - iLoad = 1: i <= (iSrcMuxSel ? adder_result : 0). iLoad = 0: i holds.
  - outLoad = 1: out <= sum, using the pre-edge value of sum, even if sum is loaded in the same cycle.
  - Latency is one cycle for every load; no bypass paths.
- Simultaneous loads:
  - sumLoad and iLoad both high with both selects = 1: both registers take the same adder_result.
  - Legal, but not issued by the controller.
- outValid: registered copy of outLoad (high exactly one cycle after each outLoad cycle, then 0 unless outLoad repeats).
- ovf:
  - Sets (<= 1) on any edge where a register is loaded from adder_result and carry = 1.
  - Clears only on reset, or on an edge with sumLoad = 1 and sumSrcMuxSel = 0 (loop initialise).
  - If a set and a clear occur in the same cycle, the clear wins.
- iLe10 updates combinationally from i, so the controller sees the new i in the cycle after iLoad.
- Nominal controller sequence and resulting datapath actions:
  - S0: sum = 0, i = 0.
  - S1: test iLe10.
  - S2: sum += i.
  - S3: i += 1.
  - S4: out = sum.
  - Back to S1; with LIMIT = 10 the run produces out = 0, 1, 3, 6, …, 55 (11 outLoads), then iLe10 = 0.
- No state machine internally; all sequencing belongs to the controller. The datapath must behave correctly for any arbitrary strobe combination.

Test Plan:
- Reset: assert reset 2 cycles with all loads high → i = sum = out = 0, ovf = 0, outValid = 0, iLe10 = 1.
- Full loop, WIDTH = 8, LIMIT = 10: drive the S0 / [S1, S2, S3, S4]×11 sequence → out steps 0, 1, 3, …, 45, 55; outValid pulses 11 times; iLe10 = 0 once i = 11; ovf = 0; out holds 55 afterwards.
- Overflow, WIDTH = 8, LIMIT = 30: same sequence → sum = 253 after adding i = 22; adding i = 23 gives sum = 20 (276 mod 256) and ovf = 1, which stays set; a new S0 clears ovf.
- outLoad with sumLoad in the same cycle (sum = 6, adderSrc = 0, i = 4) → out = 6, sum = 10 on that edge.
- Reset mid-loop (i = 5, sum = 10) → next edge i = sum = out = 0, iLe10 = 1; a subsequent run reproduces the full-loop result.
- Hold check: all loads 0 for 20 cycles with changing selects → i, sum and out unchanged; outValid stays 0.
